// File: rtl/jedro_1_mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between the IFU (read-only) and LSU ports.
// Optional macro JEDRO_1_ARB_ROUND_ROBIN_EN selects round-robin conflict resolution (default: LSU priority).
module jedro_1_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      ifu_req_i,
    input  logic [ADDR_WIDTH-1:0]     ifu_addr_i,
    output logic                      ifu_gnt_o,
    output logic                      ifu_rvalid_o,
    output logic [DATA_WIDTH-1:0]     ifu_rdata_o,
    input  logic                      lsu_req_i,
    input  logic                      lsu_we_i,
    input  logic [DATA_WIDTH/8-1:0]   lsu_be_i,
    input  logic [ADDR_WIDTH-1:0]     lsu_addr_i,
    input  logic [DATA_WIDTH-1:0]     lsu_wdata_i,
    output logic                      lsu_gnt_o,
    output logic                      lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0]     lsu_rdata_o,
    output logic                      ram_en_o,
    output logic                      ram_we_o,
    output logic [DATA_WIDTH/8-1:0]   ram_be_o,
    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        PORT_IFU = 1'b0,
        PORT_LSU = 1'b1
    } port_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    port_e            owner_q, owner_d;
    logic             we_q, we_d;
    state_e           state_s;
    logic             can_accept_s;
    logic             lsu_pri_s;
    logic             ifu_gnt_s;
    logic             lsu_gnt_s;
    logic             resp_s;

`ifdef JEDRO_1_ARB_ROUND_ROBIN_EN
    // rr_q remembers the winner of the last conflict; the other port wins the next one.
    port_e            rr_q, rr_d;

    // Round-robin priority and its update on contested grants only.
    always_comb begin
        lsu_pri_s = (rr_q == PORT_IFU);
        rr_d      = rr_q;
        if (ifu_req_i && lsu_req_i && can_accept_s) begin
            rr_d = lsu_gnt_s ? PORT_LSU : PORT_IFU;
        end else begin
            rr_d = rr_q;
        end
    end

    // Round-robin history register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_q <= PORT_IFU;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Fixed priority: the LSU wins every conflict.
    always_comb begin
        lsu_pri_s = 1'b1;
    end
`endif

    // State is carried by the remaining-cycle counter.
    always_comb begin
        state_s = ST_IDLE;
        if (cnt_q == {CNT_W{1'b0}}) begin
            state_s = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
            state_s = ST_RESP;
        end else begin
            state_s = ST_WAIT;
        end
    end

    // Same-cycle grant; a new access may overlap only the response cycle of the previous one.
    always_comb begin
        can_accept_s = (state_s != ST_WAIT);
        lsu_gnt_s    = can_accept_s && lsu_req_i && (!ifu_req_i || lsu_pri_s);
        ifu_gnt_s    = can_accept_s && ifu_req_i && !lsu_gnt_s;
        ifu_gnt_o    = ifu_gnt_s;
        lsu_gnt_o    = lsu_gnt_s;
    end

    // RAM request mux driven by the granted port.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = {BE_WIDTH{1'b0}};
        ram_addr_o  = {ADDR_WIDTH{1'b0}};
        ram_wdata_o = {DATA_WIDTH{1'b0}};
        if (lsu_gnt_s) begin
            ram_en_o    = 1'b1;
            ram_we_o    = lsu_we_i;
            ram_be_o    = lsu_we_i ? lsu_be_i : {BE_WIDTH{1'b1}};
            ram_addr_o  = lsu_addr_i;
            ram_wdata_o = lsu_we_i ? lsu_wdata_i : {DATA_WIDTH{1'b0}};
        end else if (ifu_gnt_s) begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b0;
            ram_be_o    = {BE_WIDTH{1'b1}};
            ram_addr_o  = ifu_addr_i;
            ram_wdata_o = {DATA_WIDTH{1'b0}};
        end else begin
            ram_en_o    = 1'b0;
            ram_we_o    = 1'b0;
            ram_be_o    = {BE_WIDTH{1'b0}};
            ram_addr_o  = {ADDR_WIDTH{1'b0}};
            ram_wdata_o = {DATA_WIDTH{1'b0}};
        end
    end

    // Response routing to the owner; rdata is forced to zero outside its rvalid and for write acks.
    always_comb begin
        resp_s       = (state_s == ST_RESP);
        ifu_rvalid_o = resp_s && (owner_q == PORT_IFU);
        lsu_rvalid_o = resp_s && (owner_q == PORT_LSU);
        ifu_rdata_o  = ifu_rvalid_o ? ram_rdata_i : {DATA_WIDTH{1'b0}};
        lsu_rdata_o  = (lsu_rvalid_o && !we_q) ? ram_rdata_i : {DATA_WIDTH{1'b0}};
    end

    // Next-state: a grant reloads the counter, otherwise it counts down to idle.
    always_comb begin
        cnt_d   = cnt_q;
        owner_d = owner_q;
        we_d    = we_q;
        if (ifu_gnt_s || lsu_gnt_s) begin
            cnt_d   = CNT_LOAD;
            owner_d = lsu_gnt_s ? PORT_LSU : PORT_IFU;
            we_d    = lsu_gnt_s && lsu_we_i;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Access-tracking registers; reset drops any outstanding access.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q   <= {CNT_W{1'b0}};
            owner_q <= PORT_IFU;
            we_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
        end
    end

endmodule
